// File: rtl/mem_arbiter_ctrl.sv
// Memory arbiter between I$ and D$ and a single-port variable-latency RAM.
// Holds one latched request on the RAM pins until ACCESS, ERROR or watchdog timeout.
module mem_arbiter_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [31:0] BAD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        memerr
);

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] WDOG_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        ren_q, ren_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        last_data_q, last_data_d;
    logic        memerr_q, memerr_d;

    logic        granted;
    logic        served;
    logic        aborted;
    logic        d_req;
    logic [31:0] resp_load;

    assign d_req     = dREN | dWEN;
    assign granted   = (state_q != IDLE);
    assign served    = granted && (ramstate == RAM_ACCESS);
    // ACCESS wins over a coincident timeout.
    assign aborted   = granted && !served && ((ramstate == RAM_ERROR) || (wdog_q == WDOG_LAST));
    assign resp_load = aborted ? BAD : (ren_q ? ramload : 32'h0);

    // Pins come only from registers; state gating drops enables asynchronously on reset.
    assign ramREN   = granted & ren_q;
    assign ramWEN   = granted & wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign memerr   = memerr_q;

    always_comb begin
        state_d     = state_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wdog_d      = wdog_q;
        last_data_d = last_data_q;
        memerr_d    = memerr_q;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = 32'h0;
        dload       = 32'h0;

        unique case (state_q)
            IDLE: begin
                // Data has priority, except a fetch always follows a data grant.
                if (iREN && (last_data_q || !d_req)) begin
                    state_d = IGRANT;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                    addr_d  = iaddr;
                    wdog_d  = 8'd0;
                end else if (d_req) begin
                    state_d = DGRANT;
                    ren_d   = dREN & ~dWEN;
                    wen_d   = dWEN;
                    addr_d  = daddr;
                    store_d = dstore;
                    wdog_d  = 8'd0;
                end
            end
            DGRANT: begin
                if ((served || aborted) && d_req) begin
                    dwait = 1'b0;
                    dload = resp_load;
                end
            end
            IGRANT: begin
                if ((served || aborted) && iREN) begin
                    iwait = 1'b0;
                    iload = resp_load;
                end
            end
            default: state_d = IDLE;
        endcase

        if (served || aborted) begin
            state_d     = IDLE;
            last_data_d = (state_q == DGRANT);
        end else if (granted) begin
            wdog_d = wdog_q + 8'd1;
        end

        if (aborted) begin
            memerr_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= 32'h0;
            store_q     <= 32'h0;
            wdog_q      <= 8'd0;
            last_data_q <= 1'b0;
            memerr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            wdog_q      <= wdog_d;
            last_data_q <= last_data_d;
            memerr_q    <= memerr_d;
        end
    end

endmodule
